// File: rtl/dmem_pkg.sv
// Shared types and helpers for the wait-state data memory.
package dmem_pkg;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  // Ceiling log2, used at elaboration time to size the word index.
  function automatic int log2c(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < n) r = i + 1;
    return r;
  endfunction

endpackage

// File: rtl/data_memory_ws_if.sv
// Request/response bundle between the MEM stage and data_memory_ws.
// misalign_o exists only when DMEM_ALIGN_CHK_EN is defined.
interface data_memory_ws_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  logic                    memRead_i;
  logic                    memWrite_i;
  logic [ADDR_WIDTH-1:0]   ALUOut_i;
  logic [DATA_WIDTH-1:0]   WriteData_i;
  logic [DATA_WIDTH/8-1:0] byteEn_i;
  logic [DATA_WIDTH-1:0]   ReadData_o;
  logic                    stall_o;
  logic                    done_o;
`ifdef DMEM_ALIGN_CHK_EN
  logic                    misalign_o;

  modport master (output memRead_i, memWrite_i, ALUOut_i, WriteData_i, byteEn_i,
                  input  ReadData_o, stall_o, done_o, misalign_o);
  modport slave  (input  memRead_i, memWrite_i, ALUOut_i, WriteData_i, byteEn_i,
                  output ReadData_o, stall_o, done_o, misalign_o);
`else
  modport master (output memRead_i, memWrite_i, ALUOut_i, WriteData_i, byteEn_i,
                  input  ReadData_o, stall_o, done_o);
  modport slave  (input  memRead_i, memWrite_i, ALUOut_i, WriteData_i, byteEn_i,
                  output ReadData_o, stall_o, done_o);
`endif
endinterface

// File: rtl/dmem_array.sv
// Word RAM with per-byte write enables and a registered, resettable read port.
module dmem_array #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 32,
  parameter int IW         = 5
) (
  input  logic                    gclk,
  input  logic                    grst_n,
  input  logic [DATA_WIDTH/8-1:0] we,
  input  logic                    re,
  input  logic [IW-1:0]           idx,
  input  logic [DATA_WIDTH-1:0]   wdata,
  output logic [DATA_WIDTH-1:0]   rdata
);
  localparam int BW = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Storage is deliberately not reset.
  always_ff @(posedge gclk) begin
    for (int b = 0; b < BW; b++)
      if (we[b]) mem[idx][b*8 +: 8] <= wdata[b*8 +: 8];
  end

  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n)  rdata <= '0;
    else if (re)  rdata <= mem[idx];
  end

endmodule

// File: rtl/data_memory_ws.sv
// Data memory with LATENCY wait states: latches one request, stalls the
// pipeline until it completes, then pulses done_o. DMEM_ALIGN_CHK_EN adds misalign_o.
module data_memory_ws
  import dmem_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int LATENCY    = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  data_memory_ws_if.slave  bus
);
  localparam int IW = log2c(DEPTH);
  localparam int BW = DATA_WIDTH / 8;

  state_t                state, state_nxt;
  logic [3:0]            cnt;
  logic                  op_wr;
  logic [IW-1:0]         idx;
  logic [DATA_WIDTH-1:0] wdata;
  logic [BW-1:0]         ben;
  logic                  mis_q;
  logic                  req, accept, finish;
  logic [BW-1:0]         arr_we;
  logic                  arr_re;
  logic                  unused_addr;

  assign req = bus.memRead_i | bus.memWrite_i;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    accept      = 1'b0;
    finish      = 1'b0;
    bus.stall_o = 1'b0;
    bus.done_o  = 1'b0;
    unique case (state)
      IDLE: if (req) begin
        accept      = 1'b1;
        bus.stall_o = 1'b1;
        state_nxt   = BUSY;
      end
      BUSY: begin
        bus.stall_o = 1'b1;
        if (cnt == 4'd0) begin
          finish    = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE: begin
        bus.done_o = 1'b1;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Misaligned accesses (when checked) run their full latency but touch nothing.
  assign arr_we = (finish && op_wr && !mis_q) ? ben : '0;
  assign arr_re = finish && !op_wr && !mis_q;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cnt   <= '0;
      op_wr <= 1'b0;
      idx   <= '0;
      wdata <= '0;
      ben   <= '0;
    end else if (accept) begin
      cnt   <= 4'(LATENCY - 1);
      op_wr <= bus.memWrite_i;
      idx   <= bus.ALUOut_i[IW+1:2];
      wdata <= bus.WriteData_i;
      ben   <= bus.byteEn_i;
    end else if (state == BUSY && cnt != 4'd0) begin
      cnt   <= cnt - 4'd1;
    end
  end

`ifdef DMEM_ALIGN_CHK_EN
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i)      mis_q <= 1'b0;
    else if (accept) mis_q <= |bus.ALUOut_i[1:0];
  end
  assign bus.misalign_o = (state == DONE) && mis_q;
  assign unused_addr    = ^bus.ALUOut_i[ADDR_WIDTH-1:IW+2];
`else
  assign mis_q       = 1'b0;
  assign unused_addr = ^{bus.ALUOut_i[ADDR_WIDTH-1:IW+2], bus.ALUOut_i[1:0]};
`endif

  dmem_array #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .IW         (IW)
  ) u_array (
    .gclk   (clk_i),
    .grst_n (rst_i),
    .we     (arr_we),
    .re     (arr_re),
    .idx    (idx),
    .wdata  (wdata),
    .rdata  (bus.ReadData_o)
  );

endmodule

// File: tb/tb_data_memory_ws.sv
// Directed bench for data_memory_ws: a per-cycle expectation queue built from a
// word-array memory model, plus literal checks and an LATENCY=1 back-to-back instance.
module tb_data_memory_ws;
  localparam int DW = 32, AW = 32, DEPTH = 32, LAT = 2;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  data_memory_ws_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus  ();
  data_memory_ws_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus1 ();

  data_memory_ws #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .ADDR_WIDTH(AW), .LATENCY(LAT))
    dut  (.clk_i(clk), .rst_i(rst_n), .bus(bus));
  data_memory_ws #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .ADDR_WIDTH(AW), .LATENCY(1))
    dut1 (.clk_i(clk), .rst_i(rst_n), .bus(bus1));

  typedef struct {
    logic        stall;
    logic        done;
    logic [31:0] rd;
    logic        mis;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] mdl_mem [DEPTH];
  logic [31:0] mdl_rd;
  bit          chk_on = 1'b0;
  int          checks = 0;
  int          failures = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Single compare process for the main instance.
  always @(negedge clk) begin
    if (chk_on && exp_q.size() != 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("stall", {31'd0, bus.stall_o}, {31'd0, e.stall});
      chk("done",  {31'd0, bus.done_o},  {31'd0, e.done});
      chk("rdata", bus.ReadData_o, e.rd);
`ifdef DMEM_ALIGN_CHK_EN
      chk("misalign", {31'd0, bus.misalign_o}, {31'd0, e.mis});
`endif
    end
  end

  task automatic drive(input bit wr, input bit rd, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] be);
    bus.memWrite_i  = wr;
    bus.memRead_i   = rd;
    bus.ALUOut_i    = a;
    bus.WriteData_i = d;
    bus.byteEn_i    = be;
  endtask

  task automatic push(input bit s, input bit dn, input bit mis);
    exp_t e;
    e.stall = s; e.done = dn; e.rd = mdl_rd; e.mis = mis;
    exp_q.push_back(e);
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    drive(1'b0, 1'b0, '0, '0, '0);
    repeat (n) push(1'b0, 1'b0, 1'b0);
  endtask

  // One access: acceptance cycle, LAT busy cycles, one done cycle.
  // Busy-cycle inputs carry junk to confirm the latched copies are used.
  task automatic access(input bit wr, input bit rd, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] be, input bit hold);
    int idx;
    bit mis;
    idx = int'(a[6:2]);
    mis = 1'b0;
`ifdef DMEM_ALIGN_CHK_EN
    mis = (a[1:0] != 2'b00);
`endif
    drive(wr, rd, a, d, be);
    push(1'b1, 1'b0, 1'b0);
    if (!hold) drive(1'b1, 1'b0, 32'h0000_007C, 32'hBAD0_BAD0, 4'hF);
    repeat (LAT) push(1'b1, 1'b0, 1'b0);
    if (!mis) begin
      if (wr) begin
        for (int b = 0; b < 4; b++)
          if (be[b]) mdl_mem[idx][b*8 +: 8] = d[b*8 +: 8];
      end else if (rd) begin
        mdl_rd = mdl_mem[idx];
      end
    end
    if (!hold) drive(1'b0, 1'b0, '0, '0, '0);
    push(1'b0, 1'b1, mis);
  endtask

  logic st1 [6];
  logic dn1 [6];
  int   pulses;

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    drive(1'b0, 1'b0, '0, '0, '0);
    bus1.memRead_i = 1'b0; bus1.memWrite_i = 1'b0; bus1.ALUOut_i = '0;
    bus1.WriteData_i = '0; bus1.byteEn_i = '0;
    mdl_rd = '0;
    rst_n = 1'b1;
    #3 rst_n = 1'b0;
    #1;
    chk("reset_rdata", bus.ReadData_o, 32'h0);
    chk("reset_stall", {31'd0, bus.stall_o}, 32'd0);
    chk("reset_done",  {31'd0, bus.done_o},  32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    chk_on = 1'b1;
    idle(1);

    // Aborted write: reset lands in the last busy cycle.
    access(1'b1, 1'b0, 32'h40, 32'h1111_1111, 4'hF, 1'b0);
    drive(1'b1, 1'b0, 32'h40, 32'h2222_2222, 4'hF);
    push(1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b0, '0, '0, '0);
    push(1'b1, 1'b0, 1'b0);
    chk_on = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("abort_rdata", bus.ReadData_o, 32'h0);
    chk("abort_stall", {31'd0, bus.stall_o}, 32'd0);
    chk("abort_done",  {31'd0, bus.done_o},  32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    mdl_rd = '0;
    exp_q.delete();
    chk_on = 1'b1;
    idle(2);
    access(1'b0, 1'b1, 32'h40, '0, '0, 1'b0);
    chk("abort_read", bus.ReadData_o, 32'h1111_1111);

    // Basic write/read, byte lanes, zero enables.
    access(1'b1, 1'b0, 32'h10, 32'hDEAD_BEEF, 4'hF, 1'b0);
    access(1'b0, 1'b1, 32'h10, '0, '0, 1'b0);
    chk("basic_read", bus.ReadData_o, 32'hDEAD_BEEF);
    access(1'b1, 1'b0, 32'h10, 32'h0000_00AA, 4'b0001, 1'b0);
    access(1'b0, 1'b1, 32'h10, '0, '0, 1'b0);
    chk("byte_lane", bus.ReadData_o, 32'hDEAD_BEAA);
    access(1'b1, 1'b0, 32'h10, 32'hFFFF_FFFF, 4'b0000, 1'b0);
    idle(1);
    access(1'b0, 1'b1, 32'h10, '0, '0, 1'b0);
    chk("zero_be", bus.ReadData_o, 32'hDEAD_BEAA);

    // Both request lines high is a write.
    access(1'b1, 1'b1, 32'h20, 32'h1234_5678, 4'hF, 1'b0);
    chk("rw_held", bus.ReadData_o, 32'hDEAD_BEAA);
    access(1'b0, 1'b1, 32'h20, '0, '0, 1'b0);
    chk("rw_read", bus.ReadData_o, 32'h1234_5678);

    // Address wrap and read-after-write with request held through done.
    access(1'b1, 1'b0, 32'h80, 32'h0000_0055, 4'hF, 1'b1);
    access(1'b0, 1'b1, 32'h00, '0, '0, 1'b1);
    access(1'b0, 1'b1, 32'h00, '0, '0, 1'b0);
    chk("wrap_read", bus.ReadData_o, 32'h0000_0055);

`ifdef DMEM_ALIGN_CHK_EN
    access(1'b1, 1'b0, 32'h13, 32'hCAFE_F00D, 4'hF, 1'b0);
    access(1'b0, 1'b1, 32'h10, '0, '0, 1'b0);
    chk("misalign_read", bus.ReadData_o, 32'hDEAD_BEAA);
`endif
    idle(2);
    chk_on = 1'b0;

    // LATENCY=1 instance: read held high for two accesses.
    bus1.memRead_i = 1'b1;
    bus1.ALUOut_i  = 32'h8;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      st1[i] = bus1.stall_o;
      dn1[i] = bus1.done_o;
    end
    bus1.memRead_i = 1'b0;
    pulses = 0;
    for (int i = 0; i < 6; i++) if (dn1[i]) pulses++;
    chk("b2b_stall", {26'd0, st1[0], st1[1], st1[2], st1[3], st1[4], st1[5]}, 32'b110110);
    chk("b2b_done",  {26'd0, dn1[0], dn1[1], dn1[2], dn1[3], dn1[4], dn1[5]}, 32'b001001);
    chk("b2b_pulses", pulses, 32'd2);
    repeat (2) @(posedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
